// File: rtl/rv32_branch_predictor_if.sv
// Branch predictor bundle between the RV32 pipeline and rv32_branch_predictor.
//   fetch side  : PCF -> PredTakenF, PredTargetF
//   update side : UpdValidE, UpdPCE, UpdKindE, UpdIsCallE, UpdTakenE, UpdTargetE,
//                 PredTakenE, PredTargetE -> MispredictE
//   statistics  : BrCount, MissCount
// Modports: master = pipeline (drives PC/update info), slave = predictor.
interface rv32_branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] PCF;
    logic            PredTakenF;
    logic [XLEN-1:0] PredTargetF;
    logic            UpdValidE;
    logic [XLEN-1:0] UpdPCE;
    logic [1:0]      UpdKindE;
    logic            UpdIsCallE;
    logic            UpdTakenE;
    logic [XLEN-1:0] UpdTargetE;
    logic            PredTakenE;
    logic [XLEN-1:0] PredTargetE;
    logic            MispredictE;
    logic [31:0]     BrCount;
    logic [31:0]     MissCount;

    modport master (
        output PCF, UpdValidE, UpdPCE, UpdKindE, UpdIsCallE, UpdTakenE, UpdTargetE,
               PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, MispredictE, BrCount, MissCount
    );

    modport slave (
        input  PCF, UpdValidE, UpdPCE, UpdKindE, UpdIsCallE, UpdTakenE, UpdTargetE,
               PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, MispredictE, BrCount, MissCount
    );
endinterface

// File: rtl/rv32_branch_predictor.sv
// BTB with per-entry 2-bit bimodal counters for the RV32 pipeline.
// Looks up PCF combinationally in IF, trains from resolved control flow in EX, flags EX
// mispredicts and keeps wrapping branch/mispredict counters.
// Ports:
//   CPU_CLK    rising-edge clock
//   CPU_RST_N  asynchronous active-low reset
//   bp_if      rv32_branch_predictor_if.slave (fetch lookup, EX update, counters)
// Optional feature: define BP_RAS_EN to add a RAS_DEPTH-entry circular return-address
// stack that supplies the predicted target for returns.
module rv32_branch_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned RAS_DEPTH = 4
) (
    input logic                    CPU_CLK,
    input logic                    CPU_RST_N,
    rv32_branch_predictor_if.slave bp_if
);
    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    localparam logic [1:0] KindBranch = 2'b00;
    localparam logic [1:0] KindRet    = 2'b11;

    // BTB storage
    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      kind_q   [ENTRIES];
    logic [1:0]      cnt_q    [ENTRIES];

    // Fetch lookup
    logic [IDX-1:0]  f_idx;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;
    logic [XLEN-1:0] pred_target;

    assign f_idx = bp_if.PCF[IDX+1:2];
    assign f_tag = bp_if.PCF[XLEN-1:IDX+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    // Update path
    logic [IDX-1:0]  u_idx;
    logic [TAGW-1:0] u_tag;
    logic            u_hit;
    logic            wr_en;
    logic            wr_retarget;
    logic            wr_alloc;
    logic [1:0]      wr_cnt;

    assign u_idx = bp_if.UpdPCE[IDX+1:2];
    assign u_tag = bp_if.UpdPCE[XLEN-1:IDX+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        wr_en       = 1'b0;
        wr_retarget = 1'b0;
        wr_alloc    = 1'b0;
        wr_cnt      = cnt_q[u_idx];
        if (bp_if.UpdValidE) begin
            if (u_hit) begin
                wr_en       = 1'b1;
                wr_retarget = bp_if.UpdTakenE;
                if (bp_if.UpdTakenE) begin
                    wr_cnt = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
                end else begin
                    wr_cnt = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
                end
            end else if (bp_if.UpdTakenE) begin
                // Miss + taken replaces whatever lived at this index.
                wr_en       = 1'b1;
                wr_retarget = 1'b1;
                wr_alloc    = 1'b1;
                wr_cnt      = 2'b10;
            end
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                kind_q[i]   <= KindBranch;
                cnt_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            cnt_q[u_idx] <= wr_cnt;
            if (wr_retarget) begin
                target_q[u_idx] <= bp_if.UpdTargetE;
                kind_q[u_idx]   <= bp_if.UpdKindE;
            end
            if (wr_alloc) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
            end
        end
    end

`ifdef BP_RAS_EN
    localparam int unsigned RasW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [RasW:0] RasFull = (RasW + 1)'(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [RasW-1:0] sp_q, sp_d;        // points at the top entry
    logic [RasW:0]   depth_q, depth_d;
    logic            ras_push, ras_pop, ras_we;
    logic [RasW-1:0] ras_wr_ptr;

    assign ras_push = bp_if.UpdValidE & bp_if.UpdIsCallE;
    assign ras_pop  = bp_if.UpdValidE & (bp_if.UpdKindE == KindRet);

    always_comb begin
        sp_d       = sp_q;
        depth_d    = depth_q;
        ras_we     = 1'b0;
        ras_wr_ptr = sp_q;
        if (ras_push && ras_pop) begin
            ras_we = 1'b1;
        end else if (ras_push) begin
            // Pointer wraps, so a push when full overwrites the oldest entry.
            sp_d       = sp_q + 1'b1;
            ras_wr_ptr = sp_q + 1'b1;
            ras_we     = 1'b1;
            if (depth_q != RasFull) begin
                depth_d = depth_q + 1'b1;
            end
        end else if (ras_pop && (depth_q != '0)) begin
            sp_d    = sp_q - 1'b1;
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            sp_q    <= '0;
            depth_q <= '0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            if (ras_we) begin
                ras_q[ras_wr_ptr] <= bp_if.UpdPCE + XLEN'(4);
            end
        end
    end
`else
    // Stack depth has no effect without the stack.
    localparam int unsigned UnusedRasDepth = RAS_DEPTH;
`endif

    always_comb begin
        pred_target = '0;
        if (f_hit) begin
            pred_target = target_q[f_idx];
`ifdef BP_RAS_EN
            if ((kind_q[f_idx] == KindRet) && (depth_q != '0)) begin
                pred_target = ras_q[sp_q];
            end
`endif
        end
    end

    assign bp_if.PredTakenF  = f_hit & ((kind_q[f_idx] != KindBranch) | cnt_q[f_idx][1]);
    assign bp_if.PredTargetF = pred_target;

    assign bp_if.MispredictE = bp_if.UpdValidE &
        ((bp_if.UpdTakenE != bp_if.PredTakenE) |
         (bp_if.UpdTakenE & bp_if.PredTakenE & (bp_if.UpdTargetE != bp_if.PredTargetE)));

    // Performance counters, free-running and wrapping
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign br_cnt_d   = br_cnt_q + {31'd0, bp_if.UpdValidE};
    assign miss_cnt_d = miss_cnt_q + {31'd0, bp_if.MispredictE};

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bp_if.BrCount   = br_cnt_q;
    assign bp_if.MissCount = miss_cnt_q;

    // PC byte offset is don't-care; the call flag matters only with the stack.
    logic unused_bits;
    assign unused_bits = ^{bp_if.PCF[1:0], bp_if.UpdPCE[1:0], bp_if.UpdIsCallE};

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed self-checking bench for rv32_branch_predictor (ENTRIES=64, RAS_DEPTH=4).
// The return-stack section follows BP_RAS_EN.
module tb_rv32_branch_predictor;
    logic CPU_CLK;
    logic CPU_RST_N;

    rv32_branch_predictor_if #(.XLEN(32)) bp_if ();

    rv32_branch_predictor #(
        .XLEN      (32),
        .ENTRIES   (64),
        .RAS_DEPTH (4)
    ) dut (
        .CPU_CLK   (CPU_CLK),
        .CPU_RST_N (CPU_RST_N),
        .bp_if     (bp_if)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_br   = 32'd0;
    logic [31:0] exp_miss = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One EX update lasting a single cycle; checks the mispredict flag before the edge.
    task automatic do_upd(input logic [31:0] pc, input logic [1:0] kind, input logic call,
                          input logic taken, input logic [31:0] tgt, input logic ptaken,
                          input logic [31:0] ptgt, input logic exp_mis);
        @(negedge CPU_CLK);
        bp_if.UpdValidE   = 1'b1;
        bp_if.UpdPCE      = pc;
        bp_if.UpdKindE    = kind;
        bp_if.UpdIsCallE  = call;
        bp_if.UpdTakenE   = taken;
        bp_if.UpdTargetE  = tgt;
        bp_if.PredTakenE  = ptaken;
        bp_if.PredTargetE = ptgt;
        #1;
        check_eq("mispredict", {31'd0, bp_if.MispredictE}, {31'd0, exp_mis});
        exp_br   = exp_br + 32'd1;
        exp_miss = exp_miss + {31'd0, exp_mis};
        @(posedge CPU_CLK);
        #1;
        bp_if.UpdValidE  = 1'b0;
        bp_if.UpdIsCallE = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_tgt);
        @(negedge CPU_CLK);
        bp_if.PCF = pc;
        #1;
        check_eq("pred_taken", {31'd0, bp_if.PredTakenF}, {31'd0, exp_taken});
        check_eq("pred_target", bp_if.PredTargetF, exp_tgt);
    endtask

    task automatic check_counters();
        #1;
        check_eq("br_count", bp_if.BrCount, exp_br);
        check_eq("miss_count", bp_if.MissCount, exp_miss);
    endtask

`ifdef BP_RAS_EN
    logic [31:0] ras_exp [5];
`endif

    initial begin
        CPU_RST_N         = 1'b0;
        bp_if.PCF         = 32'h100;
        bp_if.UpdValidE   = 1'b0;
        bp_if.UpdPCE      = 32'h0;
        bp_if.UpdKindE    = 2'b00;
        bp_if.UpdIsCallE  = 1'b0;
        bp_if.UpdTakenE   = 1'b0;
        bp_if.UpdTargetE  = 32'h0;
        bp_if.PredTakenE  = 1'b0;
        bp_if.PredTargetE = 32'h0;

        // T1 reset
        #1;
        check_eq("rst_pred_taken", {31'd0, bp_if.PredTakenF}, 32'd0);
        check_eq("rst_pred_target", bp_if.PredTargetF, 32'd0);
        check_eq("rst_br_count", bp_if.BrCount, 32'd0);
        check_eq("rst_miss_count", bp_if.MissCount, 32'd0);
        // Mispredict stays combinational while reset is held
        bp_if.UpdValidE = 1'b1;
        bp_if.UpdTakenE = 1'b1;
        #1;
        check_eq("rst_mispredict", {31'd0, bp_if.MispredictE}, 32'd1);
        bp_if.UpdValidE = 1'b0;
        bp_if.UpdTakenE = 1'b0;
        repeat (2) @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;

        // T2 allocate, train, saturate in both directions
        do_upd(32'h100, 2'b00, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);   // cnt 10
        look(32'h100, 1'b1, 32'h80);
        do_upd(32'h100, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);   // 01
        do_upd(32'h100, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);    // 00
        look(32'h100, 1'b0, 32'h80);
        do_upd(32'h100, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);    // stays 00
        do_upd(32'h100, 2'b00, 1'b0, 1'b1, 32'h88, 1'b0, 32'h0, 1'b1);   // 01, retarget
        look(32'h100, 1'b0, 32'h88);
        do_upd(32'h100, 2'b00, 1'b0, 1'b1, 32'h88, 1'b0, 32'h0, 1'b1);   // 10
        look(32'h100, 1'b1, 32'h88);
        do_upd(32'h100, 2'b00, 1'b0, 1'b1, 32'h88, 1'b1, 32'h88, 1'b0);  // 11
        do_upd(32'h100, 2'b00, 1'b0, 1'b1, 32'h88, 1'b1, 32'h88, 1'b0);  // stays 11
        do_upd(32'h100, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 32'h88, 1'b1);   // 10
        look(32'h100, 1'b1, 32'h88);

        // T3 alias at index 0, miss+not-taken writes nothing
        do_upd(32'h200, 2'b00, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0, 1'b1);
        look(32'h100, 1'b0, 32'h0);
        look(32'h200, 1'b1, 32'h90);
        do_upd(32'h104, 2'b00, 1'b0, 1'b0, 32'h1234, 1'b0, 32'h0, 1'b0);
        look(32'h104, 1'b0, 32'h0);

        // Non-branch kinds predict taken regardless of the counter
        do_upd(32'h10c, 2'b00, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1);   // 10
        do_upd(32'h10c, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b1);   // 01
        do_upd(32'h10c, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);     // 00
        do_upd(32'h10c, 2'b01, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1);   // 01, kind jal
        look(32'h10c, 1'b1, 32'h700);
        look(32'h10e, 1'b1, 32'h700);

        // T4 mispredict rules and counters
        do_upd(32'h110, 2'b00, 1'b0, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1);
        do_upd(32'h114, 2'b00, 1'b0, 1'b0, 32'h40, 1'b0, 32'h44, 1'b0);
        check_counters();
        @(negedge CPU_CLK);
        bp_if.UpdTakenE   = 1'b1;
        bp_if.PredTakenE  = 1'b0;
        #1;
        check_eq("mispredict_invalid", {31'd0, bp_if.MispredictE}, 32'd0);
        bp_if.UpdTakenE   = 1'b0;
        force dut.miss_cnt_q = 32'hffff_ffff;
        #1;
        release dut.miss_cnt_q;
        exp_miss = 32'hffff_ffff;
        check_counters();
        do_upd(32'h118, 2'b00, 1'b0, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1);
        check_counters();
        check_eq("miss_count_wrap", bp_if.MissCount, 32'd0);

        // T5 lookup and update of the same entry in one cycle
        @(negedge CPU_CLK);
        bp_if.PCF         = 32'h300;
        bp_if.UpdValidE   = 1'b1;
        bp_if.UpdPCE      = 32'h300;
        bp_if.UpdKindE    = 2'b00;
        bp_if.UpdTakenE   = 1'b1;
        bp_if.UpdTargetE  = 32'ha0;
        bp_if.PredTakenE  = 1'b0;
        bp_if.PredTargetE = 32'h0;
        #1;
        check_eq("same_cycle_taken", {31'd0, bp_if.PredTakenF}, 32'd0);
        check_eq("same_cycle_target", bp_if.PredTargetF, 32'd0);
        exp_br   = exp_br + 32'd1;
        exp_miss = exp_miss + 32'd1;
        @(posedge CPU_CLK);
        #1;
        bp_if.UpdValidE = 1'b0;
        check_eq("next_cycle_taken", {31'd0, bp_if.PredTakenF}, 32'd1);
        check_eq("next_cycle_target", bp_if.PredTargetF, 32'ha0);

        // T6 returns
`ifdef BP_RAS_EN
        ras_exp[0] = 32'h54;
        ras_exp[1] = 32'h44;
        ras_exp[2] = 32'h34;
        ras_exp[3] = 32'h24;
        ras_exp[4] = 32'h999;
        do_upd(32'h400, 2'b11, 1'b0, 1'b1, 32'h999, 1'b0, 32'h0, 1'b1);  // pop on empty
        for (int i = 1; i <= 5; i++) begin
            do_upd(32'(i * 16), 2'b01, 1'b1, 1'b1, 32'h800, 1'b0, 32'h0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            look(32'h400, 1'b1, ras_exp[i]);
            do_upd(32'h400, 2'b11, 1'b0, 1'b1, 32'h999, 1'b1, ras_exp[i],
                   (ras_exp[i] != 32'h999));
        end
`else
        do_upd(32'h10, 2'b01, 1'b1, 1'b1, 32'h800, 1'b0, 32'h0, 1'b1);
        do_upd(32'h400, 2'b11, 1'b0, 1'b1, 32'h999, 1'b0, 32'h0, 1'b1);
        look(32'h400, 1'b1, 32'h999);
`endif
        check_counters();

        // Asynchronous reset away from any clock edge
        @(negedge CPU_CLK);
        #2;
        bp_if.PCF = 32'h300;
        CPU_RST_N = 1'b0;
        #1;
        check_eq("async_rst_taken", {31'd0, bp_if.PredTakenF}, 32'd0);
        check_eq("async_rst_target", bp_if.PredTargetF, 32'd0);
        check_eq("async_rst_br", bp_if.BrCount, 32'd0);
        check_eq("async_rst_miss", bp_if.MissCount, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
